// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM state
// encodings, datapath selector codes and the control-vector layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // FETCH is encoded as zero so the debug state port reads 0 during reset.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_ADDI_EXEC = 4'd8,
    ST_ADDI_WB   = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/control_output_decoder.sv
// Combinational map from the controller state to the datapath control vector.
// Only FETCH looks at mem_ready, to gate the IR and PC update.
module control_output_decoder
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_ADDI_WB: ctrl.reg_write = 1'b1;
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: state register, opcode latch and next-state logic.
// Optional build macro MCU_BNE_EN adds bne (opcode 0x05) through the BRANCH state.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] in_Opcode,
  input  logic                in_MemReady,
  output logic                out_IorD,
  output logic                out_ALUSrcA,
  output logic [1:0]          out_ALUSrcB,
  output logic [1:0]          out_PCSource,
  output logic                out_RegDst,
  output logic                out_MemtoReg,
  output logic [1:0]          out_ALUOp,
  output logic                out_MemRead,
  output logic                out_MemWrite,
  output logic                out_IRWrite,
  output logic                out_PCWrite,
  output logic                out_PCWriteCond,
  output logic                out_RegWrite,
  output logic                out_BranchNE,
  output logic                out_IllegalOp,
  output logic [STATE_W-1:0]  out_State
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                illegal;
  logic                branch_ne;
  ctrl_t               ctrl, ctrl_g;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Opcode is captured in DECODE so later phases ignore whatever IR shows then.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) opcode_q <= in_Opcode;
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      ST_FETCH:     if (in_MemReady) state_d = ST_DECODE;
      ST_DECODE: begin
        case (in_Opcode)
          OPCODE_W'(OP_RTYPE):           state_d = ST_EXECUTE;
          OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): state_d = ST_MEM_ADDR;
          OPCODE_W'(OP_BEQ):             state_d = ST_BRANCH;
          OPCODE_W'(OP_ADDI):            state_d = ST_ADDI_EXEC;
          OPCODE_W'(OP_J):               state_d = ST_JUMP;
`ifdef MCU_BNE_EN
          OPCODE_W'(OP_BNE):             state_d = ST_BRANCH;
`endif
          default: begin
            state_d = ST_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode_q == OPCODE_W'(OP_SW)) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (in_MemReady) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (in_MemReady) state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  control_output_decoder u_decoder (
    .state     (state_q),
    .mem_ready (in_MemReady),
    .ctrl      (ctrl)
  );

`ifdef MCU_BNE_EN
  assign branch_ne = (state_q == ST_BRANCH) && (opcode_q == OPCODE_W'(OP_BNE));
`else
  assign branch_ne = 1'b0;
`endif

  // Everything is forced low while reset is held, so an abandoned store never writes.
  assign ctrl_g          = reset ? ctrl : '0;
  assign out_IorD        = ctrl_g.iord;
  assign out_ALUSrcA     = ctrl_g.alu_src_a;
  assign out_ALUSrcB     = ctrl_g.alu_src_b;
  assign out_PCSource    = ctrl_g.pc_source;
  assign out_RegDst      = ctrl_g.reg_dst;
  assign out_MemtoReg    = ctrl_g.mem_to_reg;
  assign out_ALUOp       = ctrl_g.alu_op;
  assign out_MemRead     = ctrl_g.mem_read;
  assign out_MemWrite    = ctrl_g.mem_write;
  assign out_IRWrite     = ctrl_g.ir_write;
  assign out_PCWrite     = ctrl_g.pc_write;
  assign out_PCWriteCond = ctrl_g.pc_write_cond;
  assign out_RegWrite    = ctrl_g.reg_write;
  assign out_BranchNE    = reset & branch_ne;
  assign out_IllegalOp   = reset & illegal;
  assign out_State       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: instruction-level phase model
// with per-cycle expected control vectors, plus reset and mid-instruction reset cases.
module tb_multicycle_control_unit;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] in_Opcode = 6'h00;
  logic       in_MemReady = 1'b0;
  logic       out_IorD, out_ALUSrcA, out_RegDst, out_MemtoReg;
  logic [1:0] out_ALUSrcB, out_PCSource, out_ALUOp;
  logic       out_MemRead, out_MemWrite, out_IRWrite, out_PCWrite;
  logic       out_PCWriteCond, out_RegWrite, out_BranchNE, out_IllegalOp;
  logic [3:0] out_State;
  logic [18:0] obs;

  int errors = 0;
  int checks = 0;

`ifdef MCU_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  multicycle_control_unit #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .in_Opcode(in_Opcode), .in_MemReady(in_MemReady),
    .out_IorD(out_IorD), .out_ALUSrcA(out_ALUSrcA), .out_ALUSrcB(out_ALUSrcB),
    .out_PCSource(out_PCSource), .out_RegDst(out_RegDst), .out_MemtoReg(out_MemtoReg),
    .out_ALUOp(out_ALUOp), .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite),
    .out_IRWrite(out_IRWrite), .out_PCWrite(out_PCWrite), .out_PCWriteCond(out_PCWriteCond),
    .out_RegWrite(out_RegWrite), .out_BranchNE(out_BranchNE), .out_IllegalOp(out_IllegalOp),
    .out_State(out_State)
  );

  always #5 clk = ~clk;

  assign obs = {out_IorD, out_ALUSrcA, out_ALUSrcB, out_PCSource, out_RegDst, out_MemtoReg,
                out_ALUOp, out_MemRead, out_MemWrite, out_IRWrite, out_PCWrite,
                out_PCWriteCond, out_RegWrite, out_BranchNE, out_IllegalOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
           (op == 6'h08) || (op == 6'h02) || (BNE_EN && op == 6'h05);
  endfunction

  // Expected outputs for one instruction phase, straight from the phase table.
  function automatic logic [18:0] exp_ctrl(input state_t ph, input logic rdy, input logic [5:0] op);
    logic iord, srca, regdst, m2r, mrd, mwr, irw, pcw, pcwc, rw, bne, ill;
    logic [1:0] srcb, pcsrc, aluop;
    {iord, srca, regdst, m2r, mrd, mwr, irw, pcw, pcwc, rw, bne, ill} = '0;
    {srcb, pcsrc, aluop} = '0;
    case (ph)
      ST_FETCH:     begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE:    begin srcb = 2'b11; ill = !is_legal(op); end
      ST_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
      ST_MEM_READ:  begin mrd = 1; iord = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; end
      ST_MEM_WRITE: begin mwr = 1; iord = 1; end
      ST_EXECUTE:   begin srca = 1; aluop = 2'b10; end
      ST_R_WB:      begin rw = 1; regdst = 1; end
      ST_ADDI_EXEC: begin srca = 1; srcb = 2'b10; end
      ST_ADDI_WB:   rw = 1;
      ST_BRANCH:    begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcwc = 1; bne = (op == 6'h05); end
      ST_JUMP:      begin pcsrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {iord, srca, srcb, pcsrc, regdst, m2r, aluop, mrd, mwr, irw, pcw, pcwc, rw, bne, ill};
  endfunction

  task automatic step(input state_t ph, input logic rdy, input logic [5:0] drv_op,
                      input logic [5:0] instr_op);
    in_MemReady = rdy;
    in_Opcode   = drv_op;
    @(negedge clk);
    check({ph.name(), "/ctrl"}, 32'(obs), 32'(exp_ctrl(ph, rdy, instr_op)));
    check({ph.name(), "/state"}, 32'(out_State), 32'(ph));
    @(posedge clk);
    #1;
  endtask

  // Memory phase: waits<0 draws ready randomly (bounded to 3 stalls), else stalls exactly waits cycles.
  task automatic mem_phase(input state_t ph, input logic [5:0] op, input int waits);
    int n = 0;
    logic rdy;
    do begin
      rdy = (waits < 0) ? (n >= 3 || $urandom_range(0, 2) != 0) : (n >= waits);
      step(ph, rdy, 6'($urandom), op);
      n++;
    end while (!rdy);
  endtask

  task automatic run_instr(input logic [5:0] op, input int waits);
    mem_phase(ST_FETCH, op, (waits < 0) ? -1 : 0);
    step(ST_DECODE, 1'($urandom), op, op);
    if (op == 6'h00) begin
      step(ST_EXECUTE, 1'($urandom), 6'($urandom), op);
      step(ST_R_WB, 1'($urandom), 6'($urandom), op);
    end else if (op == 6'h23) begin
      step(ST_MEM_ADDR, 1'($urandom), 6'($urandom), op);
      mem_phase(ST_MEM_READ, op, waits);
      step(ST_MEM_WB, 1'($urandom), 6'($urandom), op);
    end else if (op == 6'h2B) begin
      step(ST_MEM_ADDR, 1'($urandom), 6'($urandom), op);
      mem_phase(ST_MEM_WRITE, op, waits);
    end else if (op == 6'h04 || (BNE_EN && op == 6'h05)) begin
      step(ST_BRANCH, 1'($urandom), 6'($urandom), op);
    end else if (op == 6'h08) begin
      step(ST_ADDI_EXEC, 1'($urandom), 6'($urandom), op);
      step(ST_ADDI_WB, 1'($urandom), 6'($urandom), op);
    end else if (op == 6'h02) begin
      step(ST_JUMP, 1'($urandom), 6'($urandom), op);
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3F};

    reset = 1'b0;
    in_MemReady = 1'b1;
    repeat (3) begin
      in_Opcode = 6'($urandom);
      @(negedge clk);
      check("reset/ctrl", 32'(obs), 32'h0);
      check("reset/state", 32'(out_State), 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'h23, 0);
    run_instr(6'h2B, 2);
    run_instr(6'h04, 0);
    run_instr(6'h02, 0);
    run_instr(6'h3F, 0);
    run_instr(6'h05, 0);
    run_instr(6'h00, 0);
    run_instr(6'h08, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) run_instr(6'($urandom), -1);
      else                           run_instr(ops[$urandom_range(0, 7)], -1);
    end

    // Reset asserted while a store is stalled: the write must vanish immediately.
    step(ST_FETCH, 1'b1, 6'h00, 6'h2B);
    step(ST_DECODE, 1'b1, 6'h2B, 6'h2B);
    step(ST_MEM_ADDR, 1'b1, 6'h23, 6'h2B);
    step(ST_MEM_WRITE, 1'b0, 6'h00, 6'h2B);
    reset = 1'b0;
    #1;
    check("midreset/ctrl", 32'(obs), 32'h0);
    check("midreset/state", 32'(out_State), 32'h0);
    @(negedge clk);
    check("midreset2/ctrl", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(6'h00, 0);
    run_instr(6'h23, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
